// File: rtl/riscv_alu_pkg.sv
// Shared definitions for the sequential RISC-V execute ALU: op codes,
// M-group funct3 encodings and the controller state encoding.
package riscv_alu_pkg;

  typedef logic [4:0] op_t;

  // Base integer group
  localparam op_t OP_AND    = 5'h00;
  localparam op_t OP_OR     = 5'h01;
  localparam op_t OP_ADD    = 5'h02;
  localparam op_t OP_SUB    = 5'h03;
  localparam op_t OP_XOR    = 5'h04;
  localparam op_t OP_SRA    = 5'h05;
  localparam op_t OP_SLL    = 5'h06;
  localparam op_t OP_SRL    = 5'h07;
  localparam op_t OP_SLT    = 5'h08;
  localparam op_t OP_SLTU   = 5'h09;
  localparam op_t OP_NOR    = 5'h0A;

  // M group: 0x10 + funct3
  localparam op_t OP_MUL    = 5'h10;
  localparam op_t OP_MULH   = 5'h11;
  localparam op_t OP_MULHSU = 5'h12;
  localparam op_t OP_MULHU  = 5'h13;
  localparam op_t OP_DIV    = 5'h14;
  localparam op_t OP_DIVU   = 5'h15;
  localparam op_t OP_REM    = 5'h16;
  localparam op_t OP_REMU   = 5'h17;

  // op[OP_MGRP] selects the M group
  localparam int OP_MGRP = 4;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/riscv_muldiv_iter.sv
// Iterative radix-2 multiply/divide engine. Works on operand magnitudes
// (shift-add multiply, restoring divide) and applies the sign fix-up on
// the way out. res is derived from the final iteration's next value so the
// controller can register it on the same edge that completes the last step.
module riscv_muldiv_iter
  import riscv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int CW = $clog2(XLEN);

  logic                busy_q, busy_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                is_div_q, sel_q, neg_q, neg_rem_q;
  logic [XLEN-1:0]     opnd_q;
  logic [2*XLEN-1:0]   acc_q, acc_step;

  logic                sa, sb;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN:0]       mul_sum, div_sh, div_trial;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo, rem;

  // Decide which operands are treated as signed and take their magnitudes
  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    case (op)
      F3_MULH, F3_DIV, F3_REM: begin
        sa = a[XLEN-1];
        sb = b[XLEN-1];
      end
      F3_MULHSU: sa = a[XLEN-1];
      F3_MUL, F3_MULHU, F3_DIVU, F3_REMU: begin
      end
    endcase
    a_mag = sa ? -a : a;
    b_mag = sb ? -b : b;
  end

  // One radix-2 step: multiplier/quotient bits live in the low half of acc
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_sh    = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_trial = div_sh - {1'b0, opnd_q};
    if (is_div_q) begin
      acc_step = div_trial[XLEN] ? {div_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                 : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // Sign fix-up and half selection on the post-step value
  always_comb begin
    prod = neg_q ? -acc_step : acc_step;
    quo  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem  = neg_rem_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    if (is_div_q) begin
      res = sel_q ? rem : quo;
    end else begin
      res = sel_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end
  end

  // Iteration counter and busy flag next-state
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (abort) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
    end else if (busy_q) begin
      if (cnt_q == CW'(XLEN - 1)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Control registers, cleared by the asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Datapath registers: load on start, step while busy
  always_ff @(posedge clk) begin
    if (start) begin
      is_div_q  <= op[2];
      sel_q     <= op[2] ? op[1] : (op != F3_MUL);
      neg_q     <= sa ^ sb;
      neg_rem_q <= sa;
      opnd_q    <= op[2] ? b_mag : a_mag;
      acc_q     <= op[2] ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
    end else if (busy_q) begin
      acc_q <= acc_step;
    end
  end

  assign busy = busy_q;
  assign done = busy_q && (cnt_q == CW'(XLEN - 1));

endmodule

// File: rtl/riscv_alu_seq.sv
// Handshaked execute ALU: base integer ops and M-group fast paths complete
// in one cycle, the remaining M ops run on the iterative engine. Result and
// flags are registered and held until the consumer takes them.
module riscv_alu_seq
  import riscv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            carry,
  output logic            overflow
);

  localparam int SHW = $clog2(XLEN);

  state_t          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d;

  logic signed [XLEN-1:0] a_s, b_s;
  logic [SHW-1:0]  shamt;
  logic            is_sub, is_m;
  logic [XLEN-1:0] b_eff;
  logic [XLEN:0]   sum;
  logic            add_ovf;

  logic [XLEN-1:0] base_res, fast_res, imm_res;
  logic            base_c, base_o, base_legal, fast, imm_c, imm_o, imm_z;
  logic            b_zero, div_ovf;

  logic            md_start, md_abort, md_busy, md_done;
  logic [XLEN-1:0] md_res;

  assign a_s     = src_a;
  assign b_s     = src_b;
  assign shamt   = src_b[SHW-1:0];
  assign is_sub  = (op == OP_SUB);
  assign is_m    = op[OP_MGRP] && !op[3];
  assign b_eff   = is_sub ? ~src_b : src_b;
  assign sum     = {1'b0, src_a} + {1'b0, b_eff} + {{XLEN{1'b0}}, is_sub};
  assign add_ovf = (src_a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != src_a[XLEN-1]);
  assign b_zero  = (src_b == '0);
  assign div_ovf = (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == '1);

  // Single-cycle base integer operations
  always_comb begin
    base_res   = '0;
    base_c     = 1'b0;
    base_o     = 1'b0;
    base_legal = 1'b1;
    case (op)
      OP_AND:  base_res = src_a & src_b;
      OP_OR:   base_res = src_a | src_b;
      OP_XOR:  base_res = src_a ^ src_b;
      OP_NOR:  base_res = ~(src_a | src_b);
      OP_ADD, OP_SUB: begin
        base_res = sum[XLEN-1:0];
        base_c   = sum[XLEN];
        base_o   = add_ovf;
      end
      OP_SRA:  base_res = a_s >>> shamt;
      OP_SLL:  base_res = src_a << shamt;
      OP_SRL:  base_res = src_a >> shamt;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      default: base_legal = 1'b0;
    endcase
  end

  // Divide corner cases that bypass the iterative engine
  always_comb begin
    fast     = 1'b0;
    fast_res = '0;
    if (is_m && op[2]) begin
      if (b_zero) begin
        fast     = 1'b1;
        fast_res = op[1] ? src_a : '1;
      end else if (div_ovf && !op[0]) begin
        fast     = 1'b1;
        fast_res = op[1] ? '0 : src_a;
      end
    end
    imm_res = is_m ? fast_res : base_res;
    imm_c   = is_m ? 1'b0 : base_c;
    imm_o   = is_m ? 1'b0 : base_o;
    imm_z   = (is_m || base_legal) && (imm_res == '0);
  end

  // Controller next-state, engine control and result capture
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    md_start = 1'b0;
    md_abort = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          if (is_m && !fast) begin
            md_start = 1'b1;
            state_d  = CALC;
          end else begin
            result_d = imm_res;
            zero_d   = imm_z;
            carry_d  = imm_c;
            ovf_d    = imm_o;
            state_d  = DONE;
          end
        end
      end
      CALC: begin
        if (flush) begin
          md_abort = 1'b1;
          state_d  = IDLE;
        end else if (md_busy && md_done) begin
          result_d = md_res;
          zero_d   = (md_res == '0);
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (flush || out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  riscv_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (md_start),
    .abort (md_abort),
    .op    (op[2:0]),
    .a     (src_a),
    .b     (src_b),
    .busy  (md_busy),
    .done  (md_done),
    .res   (md_res)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;

endmodule
